// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter and access sequencer that shares one
// single-ported byte-addressed data memory between the CPU port (0) and the
// loader/debug port (1). One memory cycle per grant, registered outputs.
module dm_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          dm_mem_read,
  output logic          dm_mem_write,
  output logic [31:0]   dm_address,
  output logic [31:0]   dm_data_write,
  input  logic [31:0]   dm_data_read
);

  // Highest legal word address; compared on the full address width so that
  // addresses near the top of the address space never wrap into range.
  localparam logic [AW-1:0] MAX_ADDR = AW'(DEPTH - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg, last_grant_next;
  logic        id_reg, id_next;
  logic        we_reg, we_next;
  logic        ack0_reg, ack0_next;
  logic        ack1_reg, ack1_next;
  logic        err_reg, err_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic [31:0] address_reg, address_next;
  logic [31:0] data_write_reg, data_write_next;

  // Grant selection: a lone requester wins, contention goes to the port
  // that was not granted last time.
  logic          grant1;
  logic          we_sel;
  logic [AW-1:0] addr_sel;
  logic [31:0]   wdata_sel;
  logic          bad_sel;

  // Combinational grant decode and illegal-address detection
  always_comb begin
    grant1    = req1 && (!req0 || !last_grant_reg);
    we_sel    = grant1 ? we1 : we0;
    addr_sel  = grant1 ? addr1 : addr0;
    wdata_sel = grant1 ? wdata1 : wdata0;
    bad_sel   = (addr_sel[1:0] != 2'b00) || (addr_sel > MAX_ADDR);
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead
  // so that every port is driven straight from a register.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    id_next         = id_reg;
    we_next         = we_reg;
    address_next    = address_reg;
    data_write_next = data_write_reg;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    err_next        = 1'b0;
    rdata_next      = 32'h0;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          id_next         = grant1;
          we_next         = we_sel;
          last_grant_next = grant1;
          if (bad_sel) begin
            // Rejected access: answer directly, memory is never touched.
            state_next = RESP;
            ack0_next  = !grant1;
            ack1_next  = grant1;
            err_next   = 1'b1;
          end else begin
            state_next      = ACCESS;
            address_next    = 32'(addr_sel);
            data_write_next = wdata_sel;
            mem_write_next  = we_sel;
            mem_read_next   = !we_sel;
          end
        end
      end
      ACCESS: begin
        // Memory write lands and read data is captured at the edge ending ACCESS.
        state_next = RESP;
        ack0_next  = !id_reg;
        ack1_next  = id_reg;
        rdata_next = we_reg ? 32'h0 : dm_data_read;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      we_reg         <= 1'b0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg      <= 32'h0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      address_reg    <= 32'h0;
      data_write_reg <= 32'h0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      id_reg         <= id_next;
      we_reg         <= we_next;
      ack0_reg       <= ack0_next;
      ack1_reg       <= ack1_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      address_reg    <= address_next;
      data_write_reg <= data_write_next;
    end
  end

  assign ack0          = ack0_reg;
  assign ack1          = ack1_reg;
  assign err           = err_reg;
  assign rdata         = rdata_reg;
  assign dm_mem_read   = mem_read_reg;
  assign dm_mem_write  = mem_write_reg;
  assign dm_address    = address_reg;
  assign dm_data_write = data_write_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter with a
// big-endian byte memory model attached to the memory port.
module tb_dm_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [31:0]   wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err, dm_mem_read, dm_mem_write;
  logic [31:0]   rdata, dm_address, dm_data_write;
  logic [31:0]   dm_data_read = 32'h0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  int both_ack = 0;

  logic [7:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  dm_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
    .dm_address(dm_address), .dm_data_write(dm_data_write),
    .dm_data_read(dm_data_read)
  );

  // Memory write (big-endian) and cycle/strobe monitors
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_mem_write) begin
      wr_cycles <= wr_cycles + 1;
      mem[dm_address[9:0]]         = dm_data_write[31:24];
      mem[dm_address[9:0] + 10'd1] = dm_data_write[23:16];
      mem[dm_address[9:0] + 10'd2] = dm_data_write[15:8];
      mem[dm_address[9:0] + 10'd3] = dm_data_write[7:0];
    end
    if (dm_mem_read) rd_cycles <= rd_cycles + 1;
    if (ack0 && ack1) both_ack <= both_ack + 1;
  end

  // Memory read data becomes valid at the falling edge of a read cycle
  always @(negedge clk) begin
    if (dm_mem_read)
      dm_data_read <= {mem[dm_address[9:0]], mem[dm_address[9:0] + 10'd1],
                       mem[dm_address[9:0] + 10'd2], mem[dm_address[9:0] + 10'd3]};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Issue one request on a port, wait (bounded) for its ack, then release.
  task automatic run_txn(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] rd, output logic e);
    lat = -1; rd = 32'hFFFF_FFFF; e = 1'bx;
    if (port == 0) begin
      we0 = we; addr0 = addr; wdata0 = wd; req0 = 1'b1;
    end else begin
      we1 = we; addr1 = addr; wdata1 = wd; req1 = 1'b1;
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if ((port == 0) ? ack0 : ack1) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    apply_reset();
    checks++;
    if ({ack0, ack1, err, dm_mem_read, dm_mem_write} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {ack0, ack1, err, dm_mem_read, dm_mem_write});
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=00000000", rdata);
    end
    checks++;
    if ({dm_address, dm_data_write} !== 64'h0) begin
      failures++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", dm_address, dm_data_write);
    end
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd; logic e; int w0, r0;
    w0 = wr_cycles; r0 = rd_cycles;
    run_txn(0, 1'b1, 32'd8, 32'hDEAD_BEEF, lat, rd, e);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL store_latency got=%0d exp=2", lat); end
    checks++;
    if ({e, rd} !== {1'b0, 32'h0}) begin
      failures++; $display("FAIL store_resp got err=%b rdata=%h exp err=0 rdata=00000000", e, rd);
    end
    checks++;
    if ((wr_cycles - w0) !== 1 || (rd_cycles - r0) !== 0) begin
      failures++; $display("FAIL store_strobes got wr=%0d rd=%0d exp wr=1 rd=0", wr_cycles - w0, rd_cycles - r0);
    end
    w0 = wr_cycles; r0 = rd_cycles;
    run_txn(0, 1'b0, 32'd8, 32'h0, lat, rd, e);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL load_latency got=%0d exp=2", lat); end
    checks++;
    if ({e, rd} !== {1'b0, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL load_resp got err=%b rdata=%h exp err=0 rdata=deadbeef", e, rd);
    end
    checks++;
    if ((wr_cycles - w0) !== 0 || (rd_cycles - r0) !== 1) begin
      failures++; $display("FAIL load_strobes got wr=%0d rd=%0d exp wr=0 rd=1", wr_cycles - w0, rd_cycles - r0);
    end
  endtask

  task automatic test_errors;
    logic [31:0] bad_addr [4];
    int lat; logic [31:0] rd; logic e; int w0, r0;
    bad_addr[0] = 32'd6; bad_addr[1] = 32'd1024; bad_addr[2] = 32'd1021; bad_addr[3] = 32'hFFFF_FFFC;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cycles; r0 = rd_cycles;
      run_txn(i % 2, logic'(i / 2), bad_addr[i], 32'h1234_5678, lat, rd, e);
      checks++;
      if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin
        failures++;
        $display("FAIL err_addr_%h got lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=00000000", bad_addr[i], lat, e, rd);
      end
      checks++;
      if ((wr_cycles - w0) !== 0 || (rd_cycles - r0) !== 0) begin
        failures++; $display("FAIL err_strobes_%h got wr=%0d rd=%0d exp 0/0", bad_addr[i], wr_cycles - w0, rd_cycles - r0);
      end
    end
  endtask

  task automatic test_boundary;
    int lat; logic [31:0] rd; logic e;
    mem[1020] = 8'h11; mem[1021] = 8'h22; mem[1022] = 8'h33; mem[1023] = 8'h44;
    run_txn(1, 1'b0, 32'd1020, 32'h0, lat, rd, e);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'h1122_3344) begin
      failures++; $display("FAIL top_word got lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=11223344", lat, e, rd);
    end
  endtask

  task automatic test_arbitration;
    int seq_id[$]; int seq_cyc[$]; logic [31:0] seq_rd[$];
    int n0, n1, both0;
    apply_reset();
    n0 = 0; n1 = 0; both0 = both_ack;
    we0 = 1'b0; addr0 = 32'd8; we1 = 1'b0; addr1 = 32'd1020;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 60 && (n0 < 4 || n1 < 4); i++) begin
      tick();
      if (ack0) begin
        seq_id.push_back(0); seq_cyc.push_back(cyc); seq_rd.push_back(rdata);
        n0++; if (n0 == 4) req0 = 1'b0;
      end
      if (ack1) begin
        seq_id.push_back(1); seq_cyc.push_back(cyc); seq_rd.push_back(rdata);
        n1++; if (n1 == 4) req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    checks++;
    if (seq_id.size() !== 8) begin
      failures++; $display("FAIL rr_count got=%0d exp=8", seq_id.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < seq_id.size()) begin
        checks++;
        if (seq_id[i] !== (i % 2)) begin
          failures++; $display("FAIL rr_order_%0d got port=%0d exp port=%0d", i, seq_id[i], i % 2);
        end
        checks++;
        if (seq_rd[i] !== ((i % 2) ? 32'h1122_3344 : 32'hDEAD_BEEF)) begin
          failures++; $display("FAIL rr_rdata_%0d got=%h", i, seq_rd[i]);
        end
        if (i > 0) begin
          checks++;
          if (seq_cyc[i] - seq_cyc[i-1] !== 3) begin
            failures++; $display("FAIL rr_gap_%0d got=%0d exp=3", i, seq_cyc[i] - seq_cyc[i-1]);
          end
        end
      end
    end
    checks++;
    if (both_ack - both0 !== 0) begin
      failures++; $display("FAIL rr_dual_ack got=%0d exp=0", both_ack - both0);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic e; int acks;
    we1 = 1'b1; addr1 = 32'd16; wdata1 = 32'hCAFE_F00D; req1 = 1'b1;
    tick();
    checks++;
    if (dm_mem_write !== 1'b1 || dm_address !== 32'd16) begin
      failures++; $display("FAIL rstmid_access got we=%b addr=%h exp we=1 addr=00000010", dm_mem_write, dm_address);
    end
    rst = 1'b1; req1 = 1'b0;
    tick();
    checks++;
    if ({ack0, ack1, err, dm_mem_read, dm_mem_write, rdata, dm_address, dm_data_write} !== 101'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got ack=%b%b err=%b rs=%b ws=%b rdata=%h addr=%h wd=%h exp all 0",
               ack0, ack1, err, dm_mem_read, dm_mem_write, rdata, dm_address, dm_data_write);
    end
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0 || ack1) acks++;
    end
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
    run_txn(1, 1'b0, 32'd16, 32'h0, lat, rd, e);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL rstmid_readback got lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=cafef00d", lat, e, rd);
    end
  endtask

  task automatic test_back_to_back;
    int c0, c1; logic [31:0] rd1;
    c0 = -1; c1 = -1; rd1 = 32'hFFFF_FFFF;
    we0 = 1'b0; addr0 = 32'd8; req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack0) begin c0 = cyc; break; end
    end
    // During port 0's response cycle: port 0 releases, port 1 asks.
    req0 = 1'b0;
    we1 = 1'b0; addr1 = 32'd1020; req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack1) begin c1 = cyc; rd1 = rdata; break; end
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (c0 < 0 || c1 < 0 || (c1 - c0) !== 3) begin
      failures++; $display("FAIL b2b_gap got ack0@%0d ack1@%0d exp gap=3", c0, c1);
    end
    checks++;
    if (rd1 !== 32'h1122_3344) begin
      failures++; $display("FAIL b2b_rdata got=%h exp=11223344", rd1);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_store_load();
    test_errors();
    test_boundary();
    test_arbitration();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
